matrix_reader: RTL and testbench
================================

# matrix_reader

Read-side sequencer for the accelerator's operand buffers. It walks an R×C matrix stored row-major in a buffer or RAM and drives that memory's `rd`/`adr` port. It captures the combinational read data and streams one element per cycle to the MAC array over a valid/ready handshake. Transposed traversal is supported, so a stored B matrix can feed column-wise without a second copy.

## Interface
- `N`, default 8: element width in bits (matches memory `n`)
- `M`, default 4: address width (matches memory `m`); depth 2**M
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle request; sampled only in IDLE
- `base` in M: address of element (0,0)
- `rows` in M: row count R
- `cols` in M: column count C (row stride)
- `transpose` in 1: 0 = row-major order, 1 = column-major order
- `mem_rd` out 1: read enable to memory
- `mem_adr` out M: read address to memory
- `mem_data` in N: memory read data, valid combinationally in the same cycle as `mem_adr`
- `out_valid` out 1: `out_data` holds an element
- `out_ready` in 1: consumer accepts when `out_valid && out_ready` at a rising edge
- `out_data` out N: element
- `out_last` out 1: qualifies the final element of the matrix
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle pulse after the final element is accepted

## Operation
- States: IDLE, RUN, DRAIN. Reset state is IDLE. Every output resets to 0.
- IDLE with `start=1` and R,C ≠ 0: latch `base`, R, C, `transpose`; set `mem_adr=base`, r=c=0, enter RUN.
- IDLE with `start=1` and R=0 or C=0: stay in IDLE; `done`=1 for the next cycle; no elements are emitted.
- `start` in RUN or DRAIN is ignored; latched parameters stay unchanged.
- `mem_rd`=1 exactly while in RUN.
- Capture condition: RUN && (!`out_valid` || `out_ready`). On capture:
  - `out_data` ← `mem_data`; `out_valid` ← 1
  - `out_last` ← (element is final)
  - address and counters advance
- Row-major order: c increments; at c=C−1, c←0 and r increments. `mem_adr` ← `mem_adr`+1.
- Transpose order: r increments; at r=R−1, r←0 and c increments.
  - Within a column: `mem_adr` ← `mem_adr`+C.
  - At the start of a new column: `mem_adr` ← `base`+c+1.
- All address arithmetic is M bits and wraps modulo 2**M. There is no bounds error.
- Capture of the final element moves the FSM to DRAIN. `mem_adr` then holds its last value.
- Accept without a new capture clears `out_valid` and `out_last`.
- DRAIN: when the final element is accepted, go to IDLE with `done`=1 for one cycle and `out_valid`=0.

## Timing
- Latency is 1 cycle. If `start` is sampled at edge k, the element at `base` is visible after edge k+1.
- With `out_ready` held high, throughput is one element per cycle and R·C elements take R·C cycles.
- `done` rises one edge after the `out_last` handshake.
- Backpressure: while `out_valid && !out_ready`, `out_data`, `out_last` and `mem_adr` are held stable. No element is dropped or duplicated.
- A new `start` is accepted in the same cycle that `done` is high.
- Reset assertion at any time, including mid-RUN, immediately forces IDLE and zeros all outputs; no `done` pulse is issued.

## Structure
- Shared package holds:
  - state encoding (IDLE/RUN/DRAIN)
  - default `N`/`M`, shared with the buffer and RAM
- Sub-module `mr_addr_gen` is natural. It holds the r/c counters and the address register, and takes `load`, `step` and `transpose`. It returns `mem_adr` and `is_last`.
- Top level holds the FSM and the output register.

## Test plan
- Row-major: M=4, memory[i]=i+16, base=4, R=2, C=3, `out_ready`=1. `mem_adr` runs 4,5,6,7,8,9. `out_data` runs 20..25. `out_last` is high with 25. `done` pulses on the next cycle.
- Transpose: base=0, R=2, C=3. Addresses run 0,3,1,4,2,5. `out_last` is high with address 5.
- Backpressure: R=1, C=4 with `out_ready` low for 3 cycles after the second element. `out_data` and `mem_adr` hold. Exactly 4 accepts occur, in order.
- Wrap: M=4, base=14, R=1, C=4. Addresses run 14,15,0,1.
- Degenerate and ignored starts:
  - R=0: `done` pulses one cycle after `start`, `out_valid` never rises.
  - `start` during RUN changes nothing.
- Reset mid-RUN: `rst` pulled low after the 2nd element. All outputs go to 0 asynchronously. A fresh `start` after release streams from `base` correctly.

Source files
------------

// File: rtl/matrix_reader_pkg.sv
// Shared definitions for the operand-buffer read sequencer.
package matrix_reader_pkg;

  localparam int unsigned MR_N = 8;
  localparam int unsigned MR_M = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } mr_state_e;

endpackage

// File: rtl/mr_addr_gen.sv
// Row/column counters and read-address register for the matrix walk.
// is_last is registered and flags that the current address is the final element.
module mr_addr_gen
  import matrix_reader_pkg::*;
#(
  parameter int unsigned M = MR_M
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic         transpose,
  input  logic [M-1:0] base,
  input  logic [M-1:0] rows,
  input  logic [M-1:0] cols,
  output logic [M-1:0] adr,
  output logic         is_last
);

  logic [M-1:0] base_q, rows_q, cols_q, r_q, c_q;
  logic [M-1:0] base_d, rows_d, cols_d, r_d, c_d, adr_d;
  logic         tr_q, tr_d;
  logic         last_d;

  // Next counter/address values; all arithmetic wraps at M bits.
  always_comb begin
    base_d = base_q;
    rows_d = rows_q;
    cols_d = cols_q;
    tr_d   = tr_q;
    r_d    = r_q;
    c_d    = c_q;
    adr_d  = adr;
    if (load) begin
      base_d = base;
      rows_d = rows;
      cols_d = cols;
      tr_d   = transpose;
      r_d    = '0;
      c_d    = '0;
      adr_d  = base;
    end else if (step) begin
      if (!tr_q) begin
        adr_d = adr + M'(1);
        if (c_q == cols_q - M'(1)) begin
          c_d = '0;
          r_d = r_q + M'(1);
        end else begin
          c_d = c_q + M'(1);
        end
      end else begin
        if (r_q == rows_q - M'(1)) begin
          r_d   = '0;
          c_d   = c_q + M'(1);
          adr_d = base_q + c_q + M'(1);
        end else begin
          r_d   = r_q + M'(1);
          adr_d = adr + cols_q;
        end
      end
    end
    // Final element is (R-1, C-1) in either traversal order.
    last_d = (r_d == rows_d - M'(1)) && (c_d == cols_d - M'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q  <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      tr_q    <= 1'b0;
      r_q     <= '0;
      c_q     <= '0;
      adr     <= '0;
      is_last <= 1'b0;
    end else begin
      base_q  <= base_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      tr_q    <= tr_d;
      r_q     <= r_d;
      c_q     <= c_d;
      adr     <= adr_d;
      is_last <= last_d;
    end
  end

endmodule

// File: rtl/matrix_reader.sv
// Read-side sequencer: walks an RxC matrix in memory and streams one element
// per cycle over valid/ready, optionally in column-major (transposed) order.
module matrix_reader
  import matrix_reader_pkg::*;
#(
  parameter int unsigned N = MR_N,
  parameter int unsigned M = MR_M
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] base,
  input  logic [M-1:0] rows,
  input  logic [M-1:0] cols,
  input  logic         transpose,
  output logic         mem_rd,
  output logic [M-1:0] mem_adr,
  input  logic [N-1:0] mem_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  mr_state_e    state_q, state_d;
  logic         load, step, is_last;
  logic         accept, capture;
  logic [N-1:0] out_data_d;
  logic         out_valid_d, out_last_d, done_d, busy_d, mem_rd_d;

  mr_addr_gen #(.M(M)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .transpose (transpose),
    .base      (base),
    .rows      (rows),
    .cols      (cols),
    .adr       (mem_adr),
    .is_last   (is_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state and next output-register values.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    done_d      = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    accept      = out_valid && out_ready;
    capture     = (state_q == ST_RUN) && (!out_valid || out_ready);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((rows != '0) && (cols != '0)) begin
            load    = 1'b1;
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (capture) begin
          out_data_d  = mem_data;
          out_valid_d = 1'b1;
          out_last_d  = is_last;
          // The address stays on the final element once it has been read.
          step        = !is_last;
          if (is_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (accept) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d   = (state_d != ST_IDLE);
    mem_rd_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      mem_rd    <= 1'b0;
    end else begin
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      done      <= done_d;
      busy      <= busy_d;
      mem_rd    <= mem_rd_d;
    end
  end

endmodule

// File: tb/tb_matrix_reader.sv
// Directed bench for matrix_reader against a memory holding mem[i] = i + 16.
module tb_matrix_reader;

  localparam int unsigned N = 8;
  localparam int unsigned M = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         transpose = 1'b0;
  logic         out_ready = 1'b0;
  logic [M-1:0] base = '0;
  logic [M-1:0] rows = '0;
  logic [M-1:0] cols = '0;
  logic         mem_rd, out_valid, out_last, busy, done;
  logic [M-1:0] mem_adr;
  logic [N-1:0] mem_data, out_data;
  logic [N-1:0] mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_data = mem[mem_adr];

  matrix_reader #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .rows      (rows),
    .cols      (cols),
    .transpose (transpose),
    .mem_rd    (mem_rd),
    .mem_adr   (mem_adr),
    .mem_data  (mem_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // Pulse start for one edge; returns at the negedge after it was sampled.
  task automatic do_start(input logic [M-1:0] b, input logic [M-1:0] r,
                          input logic [M-1:0] c, input logic t);
    @(negedge clk);
    base = b; rows = r; cols = c; transpose = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_rd, mem_adr, out_valid, out_data, out_last, busy, done} !== '0)
      begin errors++; $display("FAIL reset_outputs got %h want 0",
        {mem_rd, mem_adr, out_valid, out_data, out_last, busy, done}); end
    rst = 1'b1;
  endtask

  task automatic test_row_major();
    logic [M-1:0] exp_adr [6];
    logic [M-1:0] nxt;
    exp_adr = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    out_ready = 1'b1;
    do_start(4'd4, 4'd2, 4'd3, 1'b0);
    checks++;
    if (mem_adr !== 4'd4 || out_valid !== 1'b0 || mem_rd !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL rm_first_adr adr=%0d valid=%b rd=%b busy=%b want 4 0 1 1",
        mem_adr, out_valid, mem_rd, busy); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== N'(20 + k) || out_last !== (k == 5))
        begin errors++; $display("FAIL rm_elem%0d data=%0d last=%b valid=%b want %0d %b 1",
          k, out_data, out_last, out_valid, 20 + k, (k == 5)); end
      nxt = (k == 5) ? exp_adr[5] : exp_adr[k + 1];
      checks++;
      if (mem_adr !== nxt)
        begin errors++; $display("FAIL rm_adr%0d got %0d want %0d", k, mem_adr, nxt); end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0)
      begin errors++; $display("FAIL rm_done done=%b valid=%b busy=%b rd=%b want 1 0 0 0",
        done, out_valid, busy, mem_rd); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0)
      begin errors++; $display("FAIL rm_done_pulse got %b want 0", done); end
  endtask

  task automatic test_transpose();
    logic [M-1:0] exp_adr [6];
    exp_adr = '{4'd0, 4'd3, 4'd1, 4'd4, 4'd2, 4'd5};
    out_ready = 1'b1;
    do_start(4'd0, 4'd2, 4'd3, 1'b1);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (mem_adr !== exp_adr[k])
        begin errors++; $display("FAIL tr_adr%0d got %0d want %0d", k, mem_adr, exp_adr[k]); end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== N'(exp_adr[k] + 16) || out_last !== (k == 5))
        begin errors++; $display("FAIL tr_elem%0d data=%0d last=%b want %0d %b",
          k, out_data, out_last, exp_adr[k] + 16, (k == 5)); end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || mem_adr !== 4'd5)
      begin errors++; $display("FAIL tr_done done=%b adr=%0d want 1 5", done, mem_adr); end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] acc [4];
    int n_acc = 0;
    logic fin = 1'b0;
    out_ready = 1'b1;
    do_start(4'd0, 4'd1, 4'd4, 1'b0);
    for (int i = 1; i <= 20 && !fin; i++) begin
      @(negedge clk);
      if (done) fin = 1'b1;
      out_ready = (i < 2 || i > 4);
      if (i >= 3 && i <= 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd17 || mem_adr !== 4'd2)
          begin errors++; $display("FAIL bp_hold%0d valid=%b data=%0d adr=%0d want 1 17 2",
            i, out_valid, out_data, mem_adr); end
      end
      if (out_valid && out_ready) begin
        if (n_acc < 4) acc[n_acc] = out_data;
        n_acc++;
      end
    end
    out_ready = 1'b1;
    checks++;
    if (fin !== 1'b1) begin errors++; $display("FAIL bp_timeout done=%b want 1", fin); end
    checks++;
    if (n_acc != 4) begin errors++; $display("FAIL bp_count got %0d want 4", n_acc); end
    for (int k = 0; k < 4 && k < n_acc; k++) begin
      checks++;
      if (acc[k] !== N'(16 + k))
        begin errors++; $display("FAIL bp_order%0d got %0d want %0d", k, acc[k], 16 + k); end
    end
  endtask

  task automatic test_wrap();
    logic [M-1:0] exp_adr [4];
    exp_adr = '{4'd14, 4'd15, 4'd0, 4'd1};
    out_ready = 1'b1;
    do_start(4'd14, 4'd1, 4'd4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_adr !== exp_adr[k])
        begin errors++; $display("FAIL wrap_adr%0d got %0d want %0d", k, mem_adr, exp_adr[k]); end
      @(negedge clk);
      checks++;
      if (out_data !== N'(exp_adr[k] + 16) || out_last !== (k == 3))
        begin errors++; $display("FAIL wrap_elem%0d data=%0d last=%b want %0d %b",
          k, out_data, out_last, exp_adr[k] + 16, (k == 3)); end
    end
    @(negedge clk);
  endtask

  task automatic test_degenerate();
    logic seen = 1'b0;
    do_start(4'd0, 4'd0, 4'd3, 1'b0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || mem_rd !== 1'b0)
      begin errors++; $display("FAIL deg_r0 done=%b busy=%b valid=%b rd=%b want 1 0 0 0",
        done, busy, out_valid, mem_rd); end
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL deg_r0_quiet valid_seen=%b done=%b want 0 0", seen, done); end
    do_start(4'd0, 4'd2, 4'd0, 1'b0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL deg_c0 done=%b busy=%b want 1 0", done, busy); end
  endtask

  task automatic test_start_ignored();
    out_ready = 1'b1;
    do_start(4'd0, 4'd1, 4'd4, 1'b0);
    base = 4'd8; rows = 4'd2; cols = 4'd2; transpose = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = (k == 0);
      checks++;
      if (out_data !== N'(16 + k) || out_last !== (k == 3) || busy !== 1'b1)
        begin errors++; $display("FAIL ign_elem%0d data=%0d last=%b busy=%b want %0d %b 1",
          k, out_data, out_last, busy, 16 + k, (k == 3)); end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || mem_adr !== 4'd3)
      begin errors++; $display("FAIL ign_done done=%b adr=%0d want 1 3", done, mem_adr); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    do_start(4'd0, 4'd1, 4'd1, 1'b0);
    @(negedge clk);
    checks++;
    if (out_data !== 8'd16 || out_last !== 1'b1)
      begin errors++; $display("FAIL b2b_first data=%0d last=%b want 16 1", out_data, out_last); end
    @(negedge clk);
    base = 4'd2; rows = 4'd1; cols = 4'd1; transpose = 1'b0; start = 1'b1;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", done); end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || mem_adr !== 4'd2)
      begin errors++; $display("FAIL b2b_restart busy=%b adr=%0d want 1 2", busy, mem_adr); end
    @(negedge clk);
    checks++;
    if (out_data !== 8'd18 || out_last !== 1'b1)
      begin errors++; $display("FAIL b2b_second data=%0d last=%b want 18 1", out_data, out_last); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    out_ready = 1'b1;
    do_start(4'd4, 4'd2, 4'd3, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (out_data !== 8'd21) begin errors++; $display("FAIL rst_pre got %0d want 21", out_data); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_rd, mem_adr, out_valid, out_data, out_last, busy, done} !== '0)
      begin errors++; $display("FAIL rst_async got %h want 0",
        {mem_rd, mem_adr, out_valid, out_data, out_last, busy, done}); end
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL rst_nodone done=%b busy=%b want 0 0", done, busy); end
    rst = 1'b1;
    do_start(4'd4, 4'd2, 4'd3, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== N'(20 + k) || out_last !== (k == 5))
        begin errors++; $display("FAIL rst_elem%0d data=%0d last=%b want %0d %b",
          k, out_data, out_last, 20 + k, (k == 5)); end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL rst_done got %b want 1", done); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = N'(i + 16);
    test_reset();
    test_row_major();
    test_transpose();
    test_backpressure();
    test_wrap();
    test_degenerate();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
